slave_port_arbiter: RTL and testbench

- Per-slave-port arbiter for the bus crossbar.
- Shares one Avalon slave port between NUM_MASTERS requesters using round-robin priority, with bus-lock support.
- Produces the registered one-hot grant that drives the slave-side mux and master waitrequest loop-back.
- Produces a one-cycle-delayed read-owner vector that steers returning read data to the master that issued the read.

---
 rtl/slave_port_arbiter_pkg.sv | 17 +
 rtl/slave_port_arbiter_if.sv | 27 ++
 rtl/rr_picker.sv | 33 +++
 rtl/slave_port_arbiter.sv | 124 ++++++++++++
 tb/tb_slave_port_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/slave_port_arbiter_pkg.sv
// Shared state encodings and defaults for the slave port arbiter.
// Optional hold timeout is enabled with SLAVE_ARB_TIMEOUT_EN.
package slave_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_OWNED   = 2'd1;
    localparam logic [1:0] ARB_RELEASE = 2'd2;

    localparam int ARB_TIMEOUT_DFLT = 256;

    typedef enum logic [1:0] {
        IDLE    = ARB_IDLE,
        OWNED   = ARB_OWNED,
        RELEASE = ARB_RELEASE
    } arb_state_t;

endpackage

// File: rtl/slave_port_arbiter_if.sv
// Request/grant bundle between the masters and one slave-port arbiter.
// master drives requests and strobes; slave is the arbiter side.
interface slave_port_arbiter_if #(
    parameter int N = 2
);

    logic [N-1:0] i_Req;
    logic [N-1:0] i_Lock;
    logic [N-1:0] i_AVIn_Read;
    logic [N-1:0] i_AVIn_Write;
    logic         i_AVOut_WaitRequest;
    logic [N-1:0] o_Gnt;
    logic [N-1:0] o_RdGnt;

    modport master (
        output i_Req, i_Lock, i_AVIn_Read, i_AVIn_Write,
        output i_AVOut_WaitRequest,
        input  o_Gnt, o_RdGnt
    );

    modport slave (
        input  i_Req, i_Lock, i_AVIn_Read, i_AVIn_Write,
        input  i_AVOut_WaitRequest,
        output o_Gnt, o_RdGnt
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester above 'last',
// found by masking a doubled request vector and taking the lowest hit.
module rr_picker #(
    parameter  int N  = 2,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] msk;
    logic [2*N-1:0] hit;
    int             first;

    always_comb begin
        dbl = {req, req};
        for (int i = 0; i < 2*N; i++) begin
            msk[i] = (i > int'(last)) && (i <= int'(last) + N);
        end
        hit   = dbl & msk;
        first = 2*N;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (hit[i]) first = i;
        end
        gnt = '0;
        for (int k = 0; k < N; k++) begin
            gnt[k] = (first == k) || (first == k + N);
        end
    end

endmodule

// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter with bus lock for one shared Avalon slave port.
// Define SLAVE_ARB_TIMEOUT_EN to force release after TIMEOUT_CYCLES.
module slave_port_arbiter
    import slave_port_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DFLT
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    slave_port_arbiter_if.slave  bus,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    localparam int N  = NUM_MASTERS;
    localparam int LW = $clog2(N);

    if (N < 2 || N > 8 || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("slave_port_arbiter: parameter out of range");
    end

    arb_state_t    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  rdgnt_q;
    logic [N-1:0]  pick;
    logic [LW-1:0] last_q, last_d;
    logic [LW-1:0] own_idx;
    logic          accept;
    logic          req_g;
    logic          lock_g;
    logic          force_rel;

    rr_picker #(.N(N)) u_pick (
        .req  (bus.i_Req),
        .last (last_q),
        .gnt  (pick)
    );

    // gnt_q is one-hot, so masked reductions select the owner's bits
    assign accept = |(gnt_q & (bus.i_AVIn_Read | bus.i_AVIn_Write))
                  & ~bus.i_AVOut_WaitRequest;
    assign req_g  = |(gnt_q & bus.i_Req);
    assign lock_g = |(gnt_q & bus.i_Lock);

    always_comb begin
        own_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_q[k]) own_idx = LW'(k);
        end
    end

`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_MAX = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] hold_q;
    logic        tmo_q;

    assign force_rel = (state_q == OWNED) && (hold_q == HOLD_MAX)
                     && !accept;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hold_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tmo_q  <= force_rel;
            hold_q <= (state_q == OWNED) ? hold_q + 16'd1 : 16'd0;
        end
    end

    assign o_Timeout = tmo_q;
`else
    assign force_rel = 1'b0;
    assign o_Timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.i_Req) begin
                    state_d = OWNED;
                    gnt_d   = pick;
                end
            end
            OWNED: begin
                if ((accept && !lock_g) || force_rel ||
                    (!accept && !bus.i_AVOut_WaitRequest && !req_g)) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    last_d  = own_idx;
                end
            end
            RELEASE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(N - 1);
            rdgnt_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rdgnt_q <= gnt_q & bus.i_AVIn_Read & {N{accept}};
        end
    end

    assign bus.o_Gnt   = gnt_q;
    assign bus.o_RdGnt = rdgnt_q;
    assign o_Busy      = |gnt_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Randomized bench for slave_port_arbiter against a transaction-level model.
// Build with SLAVE_ARB_TIMEOUT_EN to cover the forced-release path.
module tb_slave_port_arbiter;

    localparam int NM = 3;
    localparam int TO = 8;
`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic tmo;

    slave_port_arbiter_if #(.N(NM)) bus ();

    slave_port_arbiter #(
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .bus       (bus),
        .o_Busy    (busy),
        .o_Timeout (tmo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model: owner index (-1 none), release gap, rotation pointer
    int          m_own;
    int          m_last;
    int          m_cnt;
    bit          m_gap;
    bit          m_tmo;
    logic [NM-1:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     tag, $time, obs, exp);
        end
    endtask

    function automatic int rr_next(input logic [NM-1:0] r, input int last);
        for (int k = 1; k <= NM; k++) begin
            if (r[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_last = NM - 1;
        m_cnt  = 0;
        m_gap  = 1'b0;
        m_tmo  = 1'b0;
        m_rd   = '0;
    endtask

    task automatic model_clk();
        logic [NM-1:0] nrd;
        bit            ntmo;
        bit            acc;
        bit            done;
        int            o;
        int            w;
        nrd  = '0;
        ntmo = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_own >= 0) begin
            o    = m_own;
            acc  = (bus.i_AVIn_Read[o] || bus.i_AVIn_Write[o])
                   && !bus.i_AVOut_WaitRequest;
            done = 1'b0;
            if (acc && bus.i_AVIn_Read[o]) nrd[o] = 1'b1;
            if (acc) done = !bus.i_Lock[o];
            else if (TO_EN && m_cnt == TO - 1) begin
                done = 1'b1;
                ntmo = 1'b1;
            end
            else if (!bus.i_AVOut_WaitRequest && !bus.i_Req[o])
                done = 1'b1;
            if (done) begin
                m_last = o;
                m_own  = -1;
                m_gap  = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            w = rr_next(bus.i_Req, m_last);
            if (w >= 0) begin
                m_own = w;
                m_cnt = 0;
            end
        end
        m_rd  = nrd;
        m_tmo = ntmo;
    endtask

    task automatic check_outs();
        logic [31:0] eg;
        eg = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
        chk("gnt",    32'(bus.o_Gnt),   eg);
        chk("rdgnt",  32'(bus.o_RdGnt), 32'(m_rd));
        chk("busy",   32'(busy),        32'(m_own >= 0));
        chk("tmo",    32'(tmo),         32'(m_tmo));
        chk("onehot", 32'($onehot0(bus.o_Gnt)), 32'd1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clk();
        @(negedge clk);
        check_outs();
    endtask

    task automatic drive(input logic [NM-1:0] r, input logic [NM-1:0] l,
                         input logic [NM-1:0] rd, input logic [NM-1:0] wr,
                         input logic wt);
        bus.i_Req               = r;
        bus.i_Lock              = l;
        bus.i_AVIn_Read         = rd;
        bus.i_AVIn_Write        = wr;
        bus.i_AVOut_WaitRequest = wt;
    endtask

    int stuck = 0;

    initial begin
        model_reset();
        drive('0, '0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        // single unlocked write from master 0
        drive(3'b001, '0, '0, 3'b001, 1'b0);
        repeat (4) cyc();

        // all request, locked reads on master 0 with wait stuck high
        drive(3'b111, 3'b001, 3'b001, '0, 1'b1);
        repeat (12) cyc();
        drive(3'b111, 3'b001, 3'b001, '0, 1'b0);
        repeat (3) cyc();
        drive(3'b111, '0, 3'b111, '0, 1'b0);
        repeat (8) cyc();

        for (int c = 0; c < 800; c++) begin
            if (c == 290) stuck = 12;
            if (stuck == 0 && $urandom_range(0, 99) < 3) stuck = 12;
            if (stuck > 0) begin
                drive('1, '1, '0, '1, 1'b1);
                stuck--;
            end else begin
                logic [NM-1:0] r;
                for (int k = 0; k < NM; k++)
                    r[k] = ($urandom_range(0, 9) < 7);
                drive(r, NM'($urandom_range(0, 7) & $urandom_range(0, 7)),
                      NM'($urandom), NM'($urandom),
                      ($urandom_range(0, 9) < 4));
            end
            if (c == 300) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                check_outs();
                cyc();
                rst_n = 1'b1;
                drive(3'b111, '0, '0, 3'b111, 1'b0);
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
